maf_channel_scheduler: RTL and testbench

- Time-shares one moving-average filter engine among NUM_CH sample requesters.
- Round-robin arbitration issues at most one tagged sample per cycle to the engine.
- Tracks outstanding samples per channel and routes tagged engine results back to the owning channel.
- Sequences per-channel window flushes: drain, then issue a flush command to the engine, then acknowledge.

---
 rtl/maf_channel_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_maf_channel_scheduler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/maf_channel_scheduler.sv
// Shares one moving-average filter engine among NUM_CH requesters: round-robin sample issue,
// per-channel outstanding credits, tagged result routing and a drain-then-flush sequencer.
module maf_channel_scheduler #(
  parameter int NUM_CH          = 4,
  parameter int DATA_WIDTH      = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CH_W            = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            req_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] req_data,
  output logic [NUM_CH-1:0]            req_ready,
  input  logic [NUM_CH-1:0]            flush_req,
  output logic [NUM_CH-1:0]            flush_done,
  input  logic                         eng_ready,
  output logic                         eng_valid,
  output logic                         eng_flush,
  output logic [CH_W-1:0]              eng_ch,
  output logic [DATA_WIDTH-1:0]        eng_data,
  input  logic                         res_valid,
  input  logic [CH_W-1:0]              res_ch,
  input  logic [DATA_WIDTH-1:0]        res_data,
  output logic [NUM_CH-1:0]            out_valid,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
  output logic [1:0]                   dbg_flush_state
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  // Handshake: a sample moves on channel i in a cycle where req_valid[i] && req_ready[i];
  // req_ready depends on the current inputs, and the engine command follows one clock later.
  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_FLUSH, ST_DONE} flush_state_e;

  flush_state_e                  state_q, state_d;
  logic [CH_W-1:0]               fch_q, fch_d;
  logic [CH_W-1:0]               rr_ptr_q, rr_ptr_d;
  logic [NUM_CH-1:0]             pend_q, pend_d;
  logic [CNT_W-1:0]              cnt_q [NUM_CH];
  logic [CNT_W-1:0]              cnt_d [NUM_CH];
  logic                          eng_valid_q, eng_valid_d;
  logic                          eng_flush_q, eng_flush_d;
  logic [CH_W-1:0]               eng_ch_q, eng_ch_d;
  logic [DATA_WIDTH-1:0]         eng_data_q, eng_data_d;
  logic [NUM_CH-1:0]             out_valid_q, out_valid_d;
  logic [NUM_CH*DATA_WIDTH-1:0]  out_data_q, out_data_d;

  logic [NUM_CH-1:0]             elig, inc, dec;
  logic                          gnt_found;
  logic [CH_W-1:0]               gnt_idx, low_idx;
  logic                          underflow;

  // Round-robin search from rr_ptr; a channel under pending/active flush is masked.
  always_comb begin
    int idx;
    idx       = 0;
    elig      = '0;
    req_ready = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      elig[i] = !rst && req_valid[i] && (cnt_q[i] < CNT_W'(MAX_OUTSTANDING)) &&
                !pend_q[i] && (state_q != ST_FLUSH) && eng_ready;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!gnt_found && elig[CH_W'(idx)]) begin
        gnt_found = 1'b1;
        gnt_idx   = CH_W'(idx);
      end
    end
    if (gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_found) rr_ptr_d = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
  end

  // Outstanding credits; results with an out-of-range tag match no channel and are dropped.
  always_comb begin
    underflow   = 1'b0;
    out_valid_d = '0;
    out_data_d  = out_data_q;
    for (int i = 0; i < NUM_CH; i++) begin
      inc[i]   = gnt_found && (gnt_idx == CH_W'(i));
      dec[i]   = res_valid && (res_ch == CH_W'(i));
      cnt_d[i] = cnt_q[i];
      if (dec[i] && (cnt_q[i] == '0)) underflow = 1'b1;
      if (inc[i] && !dec[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec[i] && !inc[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
      if (dec[i]) begin
        out_valid_d[i] = 1'b1;
        out_data_d[i*DATA_WIDTH +: DATA_WIDTH] = res_data;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    fch_d      = fch_q;
    pend_d     = pend_q | flush_req;
    flush_done = '0;
    low_idx    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend_q[i]) low_idx = CH_W'(i);
    end
    case (state_q)
      ST_IDLE: begin
        if (|pend_q) begin
          state_d = ST_DRAIN;
          fch_d   = low_idx;
        end
      end
      // The flushing channel is masked, so cnt_d only ever falls here.
      ST_DRAIN: if (cnt_d[fch_q] == '0) state_d = ST_FLUSH;
      ST_FLUSH: if (eng_ready) state_d = ST_DONE;
      ST_DONE: begin
        flush_done[fch_q] = 1'b1;
        pend_d[fch_q]     = 1'b0;
        state_d           = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    eng_valid_d = 1'b0;
    eng_flush_d = 1'b0;
    eng_ch_d    = '0;
    eng_data_d  = '0;
    if (gnt_found) begin
      eng_valid_d = 1'b1;
      eng_ch_d    = gnt_idx;
      eng_data_d  = req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    end else if ((state_q == ST_FLUSH) && eng_ready) begin
      eng_valid_d = 1'b1;
      eng_flush_d = 1'b1;
      eng_ch_d    = fch_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      fch_q       <= '0;
      rr_ptr_q    <= '0;
      pend_q      <= '0;
      eng_valid_q <= 1'b0;
      eng_flush_q <= 1'b0;
      eng_ch_q    <= '0;
      eng_data_q  <= '0;
      out_valid_q <= '0;
      out_data_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      fch_q       <= fch_d;
      rr_ptr_q    <= rr_ptr_d;
      pend_q      <= pend_d;
      eng_valid_q <= eng_valid_d;
      eng_flush_q <= eng_flush_d;
      eng_ch_q    <= eng_ch_d;
      eng_data_q  <= eng_data_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign eng_valid       = eng_valid_q;
  assign eng_flush       = eng_flush_q;
  assign eng_ch          = eng_ch_q;
  assign eng_data        = eng_data_q;
  assign out_valid       = out_valid_q;
  assign out_data        = out_data_q;
  assign dbg_flush_state = state_q;

  // A result for a channel with nothing outstanding is an engine protocol error.
  no_result_underflow: assert property (@(posedge clk) disable iff (rst) !underflow);

endmodule

// File: tb/tb_maf_channel_scheduler.sv
// Bench for maf_channel_scheduler: directed scenarios with engine-command and
// result scoreboards checked by a monitor each cycle.
module tb_maf_channel_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  flush_req;
  logic [3:0]  flush_done;
  logic        eng_ready;
  logic        eng_valid;
  logic        eng_flush;
  logic [1:0]  eng_ch;
  logic [15:0] eng_data;
  logic        res_valid;
  logic [1:0]  res_ch;
  logic [15:0] res_data;
  logic [3:0]  out_valid;
  logic [63:0] out_data;
  logic [1:0]  dbg_flush_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [18:0] eng_exp_q[$];
  logic [17:0] res_exp_q[$];
  logic [3:0]  done_seen_q[$];

  maf_channel_scheduler dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .flush_req(flush_req), .flush_done(flush_done),
    .eng_ready(eng_ready), .eng_valid(eng_valid), .eng_flush(eng_flush),
    .eng_ch(eng_ch), .eng_data(eng_data),
    .res_valid(res_valid), .res_ch(res_ch), .res_data(res_data),
    .out_valid(out_valid), .out_data(out_data),
    .dbg_flush_state(dbg_flush_state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ch_data(input int ch);
    return 16'(16 * (ch + 1));
  endfunction

  task automatic push_eng(input logic f, input logic [1:0] ch, input logic [15:0] d);
    eng_exp_q.push_back({f, ch, d});
  endtask

  task automatic send_res(input logic [1:0] ch, input logic [15:0] d);
    res_valid = 1'b1;
    res_ch    = ch;
    res_data  = d;
    res_exp_q.push_back({ch, d});
    tick();
    res_valid = 1'b0;
  endtask

  // Monitor samples registered outputs 3 time units after each rising edge.
  always @(posedge clk) begin
    logic [18:0] e;
    logic [17:0] r;
    #3;
    if (!rst && eng_valid) begin
      if (eng_exp_q.size() == 0) begin
        check_eq("eng_unexpected", {13'd0, eng_flush, eng_ch, eng_data}, 32'd0);
      end else begin
        e = eng_exp_q.pop_front();
        check_eq("eng_cmd", {13'd0, eng_flush, eng_ch, eng_data}, {13'd0, e});
      end
    end
    if (!rst && (out_valid != 4'd0)) begin
      if (res_exp_q.size() == 0) begin
        check_eq("out_unexpected", {28'd0, out_valid}, 32'd0);
      end else begin
        r = res_exp_q.pop_front();
        check_eq("out_valid", {28'd0, out_valid}, {28'd0, 4'b0001 << r[17:16]});
        check_eq("out_data", {16'd0, out_data[r[17:16]*16 +: 16]}, {16'd0, r[15:0]});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; req_valid = '0; flush_req = '0; eng_ready = 1'b1;
    res_valid = 1'b0; res_ch = '0; res_data = '0;
    for (int c = 0; c < 4; c++) req_data[c*16 +: 16] = ch_data(c);
    #2 rst = 1'b1;
    tick(); tick();
    check_eq("rst_eng_valid", {31'd0, eng_valid}, 32'd0);
    check_eq("rst_eng_cmd", {13'd0, eng_flush, eng_ch, eng_data}, 32'd0);
    check_eq("rst_out_valid", {28'd0, out_valid}, 32'd0);
    check_eq("rst_out_data_lo", out_data[31:0], 32'd0);
    check_eq("rst_out_data_hi", out_data[63:32], 32'd0);
    check_eq("rst_flush_done", {28'd0, flush_done}, 32'd0);
    check_eq("rst_state", {30'd0, dbg_flush_state}, 32'd0);
    rst = 1'b0;
    tick();

    // Round robin, all channels requesting
    req_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) check_eq("rr_eng_valid", {31'd0, eng_valid}, 32'd1);
      if (k == 5) begin
        req_valid = 4'h0;
      end else begin
        #1;
        check_eq("rr_grant", {28'd0, req_ready}, {28'd0, 4'b0001 << (k % 4)});
        push_eng(1'b0, 2'(k % 4), ch_data(k % 4));
        tick();
      end
    end

    // Return results; ch3 checks routing and hold
    send_res(2'd0, 16'h1234);
    send_res(2'd0, 16'h8001);
    send_res(2'd1, 16'h0001);
    send_res(2'd2, 16'h7FFF);
    send_res(2'd3, 16'hFFF0);
    check_eq("route_valid", {28'd0, out_valid}, 32'h8);
    check_eq("route_data", {16'd0, out_data[63:48]}, 32'hFFF0);
    tick();
    check_eq("route_strobe_end", {28'd0, out_valid}, 32'd0);
    check_eq("route_hold3", {16'd0, out_data[63:48]}, 32'hFFF0);
    check_eq("route_hold0", {16'd0, out_data[15:0]}, 32'h8001);

    // Credit limit on ch2
    req_valid = 4'b0100;
    for (int k = 0; k < 6; k++) begin
      #1;
      check_eq("credit_grant", {28'd0, req_ready}, (k < 4) ? 32'h4 : 32'h0);
      if (k < 4) push_eng(1'b0, 2'd2, ch_data(2));
      tick();
    end
    res_valid = 1'b1; res_ch = 2'd2; res_data = 16'h0222; res_exp_q.push_back({2'd2, 16'h0222});
    #1 check_eq("credit_full_at_res", {28'd0, req_ready}, 32'h0);
    tick();
    res_valid = 1'b0;
    #1 check_eq("credit_one_more", {28'd0, req_ready}, 32'h4);
    push_eng(1'b0, 2'd2, ch_data(2));
    tick();
    res_valid = 1'b1; res_ch = 2'd2; res_data = 16'h0333; res_exp_q.push_back({2'd2, 16'h0333});
    #1 check_eq("credit_full_again", {28'd0, req_ready}, 32'h0);
    tick();
    res_data = 16'h0444; res_exp_q.push_back({2'd2, 16'h0444});
    #1 check_eq("simul_grant", {28'd0, req_ready}, 32'h4);
    push_eng(1'b0, 2'd2, ch_data(2));
    tick();
    res_valid = 1'b0;
    #1 check_eq("simul_next_grant", {28'd0, req_ready}, 32'h4);
    push_eng(1'b0, 2'd2, ch_data(2));
    tick();
    #1 check_eq("simul_count_kept", {28'd0, req_ready}, 32'h0);
    req_valid = 4'b0000;
    for (int k = 0; k < 4; k++) send_res(2'd2, 16'(16'h0500 + k));

    // Flush drain on ch1 with two outstanding
    req_valid = 4'b0010;
    for (int k = 0; k < 2; k++) begin
      #1 check_eq("fl_prefill", {28'd0, req_ready}, 32'h2);
      push_eng(1'b0, 2'd1, ch_data(1));
      tick();
    end
    req_valid = 4'b0011;
    flush_req = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      #1 check_eq("fl_ch0_served", {28'd0, req_ready}, 32'h1);
      push_eng(1'b0, 2'd0, ch_data(0));
      tick();
      flush_req = 4'b0000;
    end
    check_eq("fl_state_drain", {30'd0, dbg_flush_state}, 32'd1);
    req_valid = 4'b0010;
    #1 check_eq("fl_ch1_masked", {28'd0, req_ready}, 32'h0);
    send_res(2'd1, 16'h0A01);
    check_eq("fl_still_drain", {30'd0, dbg_flush_state}, 32'd1);
    eng_ready = 1'b0;
    send_res(2'd1, 16'h0A02);
    check_eq("fl_state_flush", {30'd0, dbg_flush_state}, 32'd2);
    req_valid = 4'b0011;
    tick();
    check_eq("fl_wait_ready", {31'd0, eng_valid}, 32'd0);
    check_eq("fl_state_hold", {30'd0, dbg_flush_state}, 32'd2);
    eng_ready = 1'b1;
    #1 check_eq("fl_blocks_grant", {28'd0, req_ready}, 32'h0);
    push_eng(1'b1, 2'd1, 16'h0000);
    tick();
    check_eq("fl_done_pulse", {28'd0, flush_done}, 32'h2);
    check_eq("fl_cmd_flush", {29'd0, eng_flush, eng_ch}, 32'h5);
    #1 check_eq("fl_grant_in_done", {28'd0, req_ready}, 32'h1);
    push_eng(1'b0, 2'd0, ch_data(0));
    tick();
    req_valid = 4'b0000;
    check_eq("fl_done_end", {28'd0, flush_done}, 32'h0);
    check_eq("fl_state_idle", {30'd0, dbg_flush_state}, 32'd0);
    for (int k = 0; k < 4; k++) send_res(2'd0, 16'(16'h0C00 + k));

    // Simultaneous flush requests: lowest index first
    flush_req = 4'b0101;
    push_eng(1'b1, 2'd0, 16'h0000);
    push_eng(1'b1, 2'd2, 16'h0000);
    tick();
    flush_req = 4'b0000;
    for (int k = 0; k < 30; k++) begin
      if (flush_done != 4'd0) done_seen_q.push_back(flush_done);
      tick();
    end
    check_eq("sim_flush_count", done_seen_q.size(), 32'd2);
    if (done_seen_q.size() >= 2) begin
      check_eq("sim_flush_first", {28'd0, done_seen_q[0]}, 32'h1);
      check_eq("sim_flush_second", {28'd0, done_seen_q[1]}, 32'h4);
    end

    // Asynchronous reset while draining ch1
    req_valid = 4'b0010;
    #1 check_eq("rd_grant", {28'd0, req_ready}, 32'h2);
    push_eng(1'b0, 2'd1, ch_data(1));
    tick();
    req_valid = 4'b0000;
    flush_req = 4'b0010;
    tick();
    flush_req = 4'b0000;
    tick();
    check_eq("rd_state_drain", {30'd0, dbg_flush_state}, 32'd1);
    req_valid = 4'hF;
    #3 rst = 1'b1;
    #1;
    check_eq("rd_req_ready", {28'd0, req_ready}, 32'h0);
    check_eq("rd_eng", {12'd0, eng_valid, eng_flush, eng_ch, eng_data}, 32'd0);
    check_eq("rd_out_valid", {28'd0, out_valid}, 32'd0);
    check_eq("rd_out_data_lo", out_data[31:0], 32'd0);
    check_eq("rd_out_data_hi", out_data[63:32], 32'd0);
    check_eq("rd_flush_done", {28'd0, flush_done}, 32'd0);
    check_eq("rd_state", {30'd0, dbg_flush_state}, 32'd0);
    tick();
    rst = 1'b0;
    #1 check_eq("rd_first_grant", {28'd0, req_ready}, 32'h1);
    push_eng(1'b0, 2'd0, ch_data(0));
    tick();
    req_valid = 4'b0000;
    tick(); tick();

    check_eq("eng_queue_empty", eng_exp_q.size(), 32'd0);
    check_eq("res_queue_empty", res_exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
